spi_responder: RTL

//   Peripheral (responder) end of the team's 1-wire-MOSI/1-wire-MISO SPI link; pairs with spi_controller.

---
 rtl/spi_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// SPI responder: deserialises {data,addr,wr} frames sent LSB-first on mosi while cs is low,
// stores writes in a DEPTH x DW register file and shifts read data back LSB-first on miso.
module spi_responder #(
   parameter int DEPTH = 32,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic cs,
   input  logic mosi,
   output logic miso,
   output logic ready,
   output logic op_done,
   output logic err
);

   localparam int MAXW = (AW > DW) ? AW : DW;
   localparam int CW   = $clog2(MAXW + 1);
   localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

   typedef enum logic [2:0] {
      IDLE,
      RX_ADDR,
      RX_DATA,
      WRITE,
      RD_PREP,
      RD_SEND
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          armed;
   logic          wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic [DW-1:0] shift;
   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] addr_next;
   logic          addr_ok;
   logic          addr_next_ok;

   // Range checks use the full address width so out-of-range addresses never alias into storage.
   assign addr_next    = {mosi, addr[AW-1:1]};
   assign addr_ok      = ({1'b0, addr} < DEPTH_W);
   assign addr_next_ok = ({1'b0, addr_next} < DEPTH_W);

   // Single FSM; pulse outputs default low every cycle so they can never stretch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         armed   <= 1'b1;
         wr      <= 1'b0;
         addr    <= '0;
         data    <= '0;
         shift   <= '0;
         miso    <= 1'b0;
         ready   <= 1'b0;
         op_done <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         ready   <= 1'b0;
         op_done <= 1'b0;
         err     <= 1'b0;
         if (cs) begin
            armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (!cs && armed) begin
                  wr    <= mosi;
                  armed <= 1'b0;
                  cnt   <= '0;
                  addr  <= '0;
                  data  <= '0;
                  state <= RX_ADDR;
               end
            end

            RX_ADDR: begin
               if (cs) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  addr <= addr_next;
                  if (cnt == ADDR_LAST) begin
                     cnt <= '0;
                     if (wr) begin
                        state <= RX_DATA;
                     end else begin
                        ready <= 1'b1;
                        err   <= ~addr_next_ok;
                        state <= RD_PREP;
                     end
                  end else if (cnt != '1) begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            RX_DATA: begin
               if (cs) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  data <= {mosi, data[DW-1:1]};
                  if (cnt == DATA_LAST) begin
                     cnt     <= '0;
                     op_done <= 1'b1;
                     err     <= ~addr_ok;
                     state   <= WRITE;
                  end else if (cnt != '1) begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            WRITE: begin
               if (addr_ok) begin
                  mem[addr[IW-1:0]] <= data;
               end
               state <= IDLE;
            end

            // Bit 0 goes straight onto miso here so it appears the cycle after ready.
            RD_PREP: begin
               if (addr_ok) begin
                  miso  <= mem[addr[IW-1:0]][0];
                  shift <= mem[addr[IW-1:0]] >> 1;
               end else begin
                  miso  <= 1'b0;
                  shift <= '0;
               end
               cnt   <= '0;
               state <= RD_SEND;
            end

            RD_SEND: begin
               if (cnt == DATA_LAST) begin
                  miso  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  miso  <= shift[0];
                  shift <= shift >> 1;
                  if (cnt != '1) begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
